// File: rtl/buf_audio_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buf_audio_rd_pkg
// Description : Shared types and width helpers for the audio read scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package buf_audio_rd_pkg;

  localparam int STEREO_MULTIPLIER      = 2;
  localparam int c_DEF_NUM_AUDIO_CHANNELS = 2;
  localparam int c_DEF_NUM_CONSUMERS      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    POP   = 2'd2,
    SERVE = 2'd3
  } sched_state_t;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold 0 .. cycles-1.
  function automatic int tmo_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  typedef logic [idx_width(c_DEF_NUM_AUDIO_CHANNELS)-1:0] pair_idx_t;
  typedef logic [idx_width(c_DEF_NUM_CONSUMERS)-1:0]      cons_idx_t;

endpackage
`default_nettype wire

// File: rtl/buf_audio_rd_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; grants the lowest set
//               request at or after the pointer, as a one-hot vector.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int PTR_W = 2
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [WIDTH-1:0] o_grant
);

  int w_idx;

  // Scan offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    o_grant = '0;
    w_idx   = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= WIDTH) w_idx = w_idx - WIDTH;
      if (|(i_req & (WIDTH'(1) << w_idx))) o_grant = WIDTH'(1) << w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/buf_audio_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : buf_audio_rd_sched
// Description : Pops frames from buf_audio_in and serves them round-robin to
//               DSP consumers. Optional stats: BUF_AUDIO_RD_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module buf_audio_rd_sched
  import buf_audio_rd_pkg::*;
#(
  parameter int NUM_AUDIO_CHANNELS = 2,
  parameter int AUDIO_WIDTH        = 24,
  parameter int NUM_CONSUMERS      = 4,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                                                  sys_clk,
  input  logic                                                  sys_rst,
  input  logic                                                  buffer_ready,
  input  logic                                                  buffer_full,
  input  logic [STEREO_MULTIPLIER*NUM_AUDIO_CHANNELS-1:0][AUDIO_WIDTH-1:0] audio_channel_in,
  output logic                                                  adv_read_req,
  output logic                                                  adv_read_enable,
  input  logic [NUM_CONSUMERS-1:0]                              cons_sub,
  input  logic [NUM_CONSUMERS-1:0][idx_width(NUM_AUDIO_CHANNELS)-1:0] cons_pair_sel,
  input  logic [NUM_CONSUMERS-1:0]                              cons_ready,
  output logic [NUM_CONSUMERS-1:0]                              cons_grant,
  output logic [AUDIO_WIDTH-1:0]                                out_left,
  output logic [AUDIO_WIDTH-1:0]                                out_right,
  output logic                                                  frame_done,
  output logic [NUM_CONSUMERS-1:0]                              timeout_err
`ifdef BUF_AUDIO_RD_SCHED_STATS_EN
  ,
  output logic [31:0]                                           stat_frames,
  output logic [15:0]                                           stat_overruns
`endif
);

  localparam int c_N_SAMP = STEREO_MULTIPLIER * NUM_AUDIO_CHANNELS;
  localparam int c_PAIR_W = idx_width(NUM_AUDIO_CHANNELS);
  localparam int c_CONS_W = idx_width(NUM_CONSUMERS);
  localparam int c_TMO_W  = tmo_width(TIMEOUT_CYCLES);

  sched_state_t                                r_state;
  sched_state_t                                w_state_next;
  logic [c_N_SAMP-1:0][AUDIO_WIDTH-1:0]        r_frame;
  logic [NUM_CONSUMERS-1:0]                    r_pending;
  logic [NUM_CONSUMERS-1:0][c_PAIR_W-1:0]      r_pair_sel;
  logic [c_CONS_W-1:0]                         r_ptr;
  logic [c_TMO_W-1:0]                          r_tmo_cnt;
  logic [NUM_CONSUMERS-1:0]                    r_grant;
  logic [NUM_CONSUMERS-1:0]                    r_timeout_err;

  logic [NUM_CONSUMERS-1:0]                    w_arb_grant;
  logic [c_CONS_W-1:0]                         w_grant_idx;
  logic [c_CONS_W-1:0]                         w_ptr_next;
  logic [c_PAIR_W-1:0]                         w_pair;
  logic                                        w_any_grant;
  logic                                        w_xfer;
  logic                                        w_tmo;

  rr_arbiter #(
    .WIDTH (NUM_CONSUMERS),
    .PTR_W (c_CONS_W)
  ) u_rr_arbiter (
    .i_req   (r_pending),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant)
  );

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (r_grant[i]) w_grant_idx = c_CONS_W'(i);
    end
  end

  assign w_any_grant = |r_grant;
  // A ready arriving on the final timeout cycle is a normal transfer.
  assign w_xfer      = |(r_grant & cons_ready);
  assign w_tmo       = w_any_grant && !w_xfer &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_ptr_next  = (w_grant_idx == c_CONS_W'(NUM_CONSUMERS - 1)) ? '0
                                                                      : w_grant_idx + 1'b1;
  assign w_pair      = r_pair_sel[w_grant_idx];

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    adv_read_req    = 1'b0;
    adv_read_enable = 1'b0;
    frame_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (buffer_ready && (|cons_sub)) w_state_next = LATCH;
      end
      LATCH: begin
        adv_read_req = 1'b1;
        w_state_next = POP;
      end
      POP: begin
        adv_read_req    = 1'b1;
        adv_read_enable = 1'b1;
        w_state_next    = SERVE;
      end
      SERVE: begin
        if (!w_any_grant && (r_pending == '0)) begin
          frame_done   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_frame       <= '0;
      r_pending     <= '0;
      r_pair_sel    <= '0;
      r_ptr         <= '0;
      r_tmo_cnt     <= '0;
      r_grant       <= '0;
      r_timeout_err <= '0;
    end else begin
      case (r_state)
        LATCH: begin
          r_frame   <= audio_channel_in;
          r_pending <= cons_sub;
          r_tmo_cnt <= '0;
          r_grant   <= '0;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (int'(cons_pair_sel[i]) >= NUM_AUDIO_CHANNELS) r_pair_sel[i] <= '0;
            else                                              r_pair_sel[i] <= cons_pair_sel[i];
          end
        end
        POP: r_grant <= w_arb_grant;
        SERVE: begin
          if (w_any_grant) begin
            if (w_xfer || w_tmo) begin
              r_pending <= r_pending & ~r_grant;
              r_ptr     <= w_ptr_next;
              r_tmo_cnt <= '0;
              r_grant   <= '0;
              if (w_tmo) r_timeout_err <= r_timeout_err | r_grant;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end else begin
            // Idle slot between grants; the arbiter picks the next consumer.
            r_grant <= w_arb_grant;
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

  always_comb begin
    out_left  = '0;
    out_right = '0;
    if (w_any_grant) begin
      for (int p = 0; p < NUM_AUDIO_CHANNELS; p++) begin
        if (w_pair == c_PAIR_W'(p)) begin
          out_left  = r_frame[STEREO_MULTIPLIER*p];
          out_right = r_frame[STEREO_MULTIPLIER*p+1];
        end
      end
    end
  end

  assign cons_grant  = r_grant;
  assign timeout_err = r_timeout_err;

`ifdef BUF_AUDIO_RD_SCHED_STATS_EN
  logic [31:0] r_stat_frames;
  logic [15:0] r_stat_overruns;
  logic        r_full_d;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_stat_frames   <= '0;
      r_stat_overruns <= '0;
      r_full_d        <= 1'b0;
    end else begin
      r_full_d <= buffer_full;
      if (r_state == POP) r_stat_frames <= r_stat_frames + 32'd1;
      if (buffer_full && !r_full_d && (r_state != IDLE) &&
          (r_stat_overruns != 16'hFFFF))
        r_stat_overruns <= r_stat_overruns + 16'd1;
    end
  end

  assign stat_frames   = r_stat_frames;
  assign stat_overruns = r_stat_overruns;
`else
  logic w_unused_full;
  assign w_unused_full = buffer_full;
`endif

endmodule
`default_nettype wire

// File: tb/tb_buf_audio_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_buf_audio_rd_sched
// Description : Directed self-checking bench for buf_audio_rd_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buf_audio_rd_sched;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b0;
  logic             buffer_ready = 1'b0;
  logic             buffer_full = 1'b0;
  logic [3:0][23:0] audio_channel_in = '0;
  logic             adv_read_req;
  logic             adv_read_enable;
  logic [3:0]       cons_sub = '0;
  logic [3:0][0:0]  cons_pair_sel = '0;
  logic [3:0]       cons_ready = '0;
  logic [3:0]       cons_grant;
  logic [23:0]      out_left;
  logic [23:0]      out_right;
  logic             frame_done;
  logic [3:0]       timeout_err;
`ifdef BUF_AUDIO_RD_SCHED_STATS_EN
  logic [31:0]      stat_frames;
  logic [15:0]      stat_overruns;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int pop_cnt    = 0;

  int          gq[$];
  int          gs[$];
  int          hq[$];
  logic [23:0] lq[$];
  logic [23:0] rq[$];
  int          pop_k, first_k, done_k, done_n, pops_n;

  buf_audio_rd_sched #(
    .NUM_AUDIO_CHANNELS (2),
    .AUDIO_WIDTH        (24),
    .NUM_CONSUMERS      (4),
    .TIMEOUT_CYCLES     (8)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .buffer_ready     (buffer_ready),
    .buffer_full      (buffer_full),
    .audio_channel_in (audio_channel_in),
    .adv_read_req     (adv_read_req),
    .adv_read_enable  (adv_read_enable),
    .cons_sub         (cons_sub),
    .cons_pair_sel    (cons_pair_sel),
    .cons_ready       (cons_ready),
    .cons_grant       (cons_grant),
    .out_left         (out_left),
    .out_right        (out_right),
    .frame_done       (frame_done),
    .timeout_err      (timeout_err)
`ifdef BUF_AUDIO_RD_SCHED_STATS_EN
    ,
    .stat_frames      (stat_frames),
    .stat_overruns    (stat_overruns)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (adv_read_enable) pop_cnt <= pop_cnt + 1;

  function automatic int onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g == (4'b0001 << i)) return i;
    return -1;
  endfunction

  task automatic do_reset();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
  endtask

  // Observes one frame from the current negedge (k=0) until frame_done.
  task automatic run_frame(input int max_cycles, input bit perturb);
    logic [3:0] prev;
    int k, hold;
    gq.delete(); gs.delete(); hq.delete(); lq.delete(); rq.delete();
    pop_k = -1; first_k = -1; done_k = -1; done_n = 0; pops_n = 0;
    prev = '0; k = 0; hold = 0;
    while (done_n == 0 && k < max_cycles) begin
      @(negedge sys_clk);
      k++;
      if (adv_read_enable) begin
        pops_n++;
        if (pop_k < 0) pop_k = k;
      end
      if (prev != 0 && cons_grant != prev) hq.push_back(hold);
      if (cons_grant != 0 && cons_grant != prev) begin
        gq.push_back(onehot_idx(cons_grant));
        gs.push_back(k);
        lq.push_back(out_left);
        rq.push_back(out_right);
        hold = 0;
        if (first_k < 0) first_k = k;
      end
      if (cons_grant != 0) hold++;
      if (frame_done) begin
        done_n++;
        done_k = k;
      end
      if (perturb && k == 2) begin
        audio_channel_in = {24'hDEAD01, 24'hDEAD02, 24'hDEAD03, 24'hDEAD04};
        cons_sub         = 4'b1111;
        cons_pair_sel    = 4'b1111;
        buffer_ready     = 1'b0;
      end
      prev = cons_grant;
    end
    vectors++;
    if (done_n == 0) begin
      miscompares++;
      $display("FAIL frame_wait: frame_done not seen within %0d cycles", max_cycles);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if ({adv_read_req, adv_read_enable, cons_grant, out_left, out_right, frame_done, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b en=%b grant=%b L=%h R=%h done=%b err=%b, want all 0",
               adv_read_req, adv_read_enable, cons_grant, out_left, out_right, frame_done, timeout_err);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    vectors++;
    if ({adv_read_req, cons_grant, frame_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_release_idle: req=%b grant=%b done=%b, want 0", adv_read_req, cons_grant, frame_done);
    end
  endtask

  task automatic test_frame_serve();
    int p0;
    do_reset();
    audio_channel_in = {24'h222222, 24'h111111, 24'hABCDEF, 24'h123456};
    cons_sub      = 4'b0011;
    cons_pair_sel = 4'b0010;
    cons_ready    = 4'b1111;
    buffer_ready  = 1'b1;
    p0 = pop_cnt;
    run_frame(30, 1'b1);
    vectors++;
    if (pop_k !== 2 || pops_n !== 1) begin
      miscompares++;
      $display("FAIL serve_pop: pop at k=%0d count=%0d, want k=2 count=1", pop_k, pops_n);
    end
    vectors++;
    if (gq.size() !== 2 || gq[0] !== 0 || gq[1] !== 1) begin
      miscompares++;
      $display("FAIL serve_order: got %0d grants first=%0d second=%0d, want 2 grants 0,1",
               gq.size(), gq[0], gq[1]);
    end
    vectors++;
    if (first_k !== 3 || gs[1] !== 5 || hq[0] !== 1 || hq[1] !== 1) begin
      miscompares++;
      $display("FAIL serve_timing: grants at %0d,%0d holds %0d,%0d, want 3,5 holds 1,1",
               first_k, gs[1], hq[0], hq[1]);
    end
    vectors++;
    if (lq[0] !== 24'h123456 || rq[0] !== 24'hABCDEF) begin
      miscompares++;
      $display("FAIL serve_data_c0: got %h/%h, want 123456/abcdef", lq[0], rq[0]);
    end
    vectors++;
    if (lq[1] !== 24'h111111 || rq[1] !== 24'h222222) begin
      miscompares++;
      $display("FAIL serve_data_c1: got %h/%h, want 111111/222222", lq[1], rq[1]);
    end
    vectors++;
    if (done_k !== 6) begin
      miscompares++;
      $display("FAIL serve_done_cycle: got k=%0d, want 6", done_k);
    end
    @(negedge sys_clk);
    vectors++;
    if ({adv_read_req, cons_grant, frame_done} !== '0) begin
      miscompares++;
      $display("FAIL serve_back_idle: req=%b grant=%b done=%b, want 0", adv_read_req, cons_grant, frame_done);
    end
    repeat (4) @(negedge sys_clk);
    vectors++;
    if (pop_cnt - p0 !== 1) begin
      miscompares++;
      $display("FAIL serve_single_pop: got %0d pops, want 1", pop_cnt - p0);
    end
  endtask

  task automatic test_round_robin();
    int p0;
    logic [23:0] exp_l;
    do_reset();
    audio_channel_in = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
    cons_sub      = 4'b1111;
    cons_pair_sel = 4'b1010;
    cons_ready    = 4'b1111;
    buffer_ready  = 1'b1;
    p0 = pop_cnt;
    for (int f = 0; f < 3; f++) begin
      run_frame(40, 1'b0);
      if (f == 2) buffer_ready = 1'b0;
      vectors++;
      if (gq.size() !== 4) begin
        miscompares++;
        $display("FAIL rr_count frame %0d: got %0d grants, want 4", f, gq.size());
      end
      for (int j = 0; j < 4; j++) begin
        exp_l = (j % 2 == 0) ? 24'h000001 : 24'h000003;
        vectors++;
        if (gq[j] !== j || lq[j] !== exp_l) begin
          miscompares++;
          $display("FAIL rr_order frame %0d slot %0d: got consumer %0d L=%h, want consumer %0d L=%h",
                   f, j, gq[j], lq[j], j, exp_l);
        end
      end
    end
    repeat (6) @(negedge sys_clk);
    vectors++;
    if (pop_cnt - p0 !== 3) begin
      miscompares++;
      $display("FAIL rr_pops: got %0d, want 3", pop_cnt - p0);
    end
  endtask

  task automatic test_timeout();
    int n, hold;
    do_reset();
    audio_channel_in = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
    cons_sub      = 4'b0111;
    cons_pair_sel = 4'b0000;
    cons_ready    = 4'b0101;
    buffer_ready  = 1'b1;
    run_frame(60, 1'b0);
    buffer_ready = 1'b0;
    vectors++;
    if (gq.size() !== 3 || gq[0] !== 0 || gq[1] !== 1 || gq[2] !== 2) begin
      miscompares++;
      $display("FAIL tmo_order: got %0d grants %0d,%0d,%0d, want 0,1,2", gq.size(), gq[0], gq[1], gq[2]);
    end
    vectors++;
    if (hq[0] !== 1 || hq[1] !== 8 || hq[2] !== 1) begin
      miscompares++;
      $display("FAIL tmo_hold: got holds %0d,%0d,%0d, want 1,8,1", hq[0], hq[1], hq[2]);
    end
    vectors++;
    if (timeout_err !== 4'b0010) begin
      miscompares++;
      $display("FAIL tmo_err: got %b, want 0010", timeout_err);
    end
    // Consumer 3 asserts ready on the last allowed cycle: a transfer, not an error.
    cons_sub     = 4'b1000;
    cons_ready   = 4'b0000;
    buffer_ready = 1'b1;
    n = 0; hold = 0;
    while (hold < 8 && n < 30) begin
      @(negedge sys_clk);
      n++;
      if (n == 2) buffer_ready = 1'b0;
      if (cons_grant == 4'b1000) begin
        hold++;
        if (hold == 8) cons_ready = 4'b1000;
      end
    end
    vectors++;
    if (hold !== 8) begin
      miscompares++;
      $display("FAIL tie_hold: grant seen %0d cycles, want 8", hold);
    end
    @(negedge sys_clk);
    vectors++;
    if (cons_grant !== 4'b0000 || frame_done !== 1'b1 || timeout_err !== 4'b0010) begin
      miscompares++;
      $display("FAIL tie_result: grant=%b done=%b err=%b, want 0000/1/0010", cons_grant, frame_done, timeout_err);
    end
  endtask

  task automatic test_no_subscribers();
    int p0;
    do_reset();
    cons_sub      = 4'b0000;
    cons_pair_sel = 4'b0000;
    cons_ready    = 4'b1111;
    buffer_ready  = 1'b1;
    p0 = pop_cnt;
    repeat (100) @(negedge sys_clk);
    vectors++;
    if (pop_cnt - p0 !== 0 || adv_read_req !== 1'b0) begin
      miscompares++;
      $display("FAIL nosub_pops: got %0d pops req=%b, want 0 pops req=0", pop_cnt - p0, adv_read_req);
    end
    cons_sub = 4'b0001;
    run_frame(20, 1'b0);
    buffer_ready = 1'b0;
    vectors++;
    if (pop_k !== 2 || pops_n !== 1 || gq.size() !== 1 || gq[0] !== 0) begin
      miscompares++;
      $display("FAIL nosub_then_sub: pop k=%0d count=%0d grants=%0d, want k=2 count=1 grants=1",
               pop_k, pops_n, gq.size());
    end
  endtask

  task automatic test_mid_frame_reset();
    int n, p0;
    vectors++;
    if (timeout_err !== 4'b0010) begin
      miscompares++;
      $display("FAIL sticky_err: got %b, want 0010", timeout_err);
    end
    cons_sub     = 4'b0011;
    cons_ready   = 4'b0000;
    buffer_ready = 1'b1;
    n = 0;
    while (cons_grant == 0 && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    buffer_ready = 1'b0;
    vectors++;
    if (cons_grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_pre_grant: got %b, want 0001", cons_grant);
    end
    #2 sys_rst = 1'b0;
    #1;
    vectors++;
    if ({adv_read_req, adv_read_enable, cons_grant, out_left, out_right, frame_done} !== '0) begin
      miscompares++;
      $display("FAIL rst_async_outputs: req=%b en=%b grant=%b L=%h R=%h done=%b, want 0",
               adv_read_req, adv_read_enable, cons_grant, out_left, out_right, frame_done);
    end
    vectors++;
    if (timeout_err !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_err_clear: got %b, want 0000", timeout_err);
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    p0 = pop_cnt;
    repeat (5) @(negedge sys_clk);
    vectors++;
    if (pop_cnt - p0 !== 0 || cons_grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_no_repop: got %0d pops grant=%b, want 0 pops grant 0000", pop_cnt - p0, cons_grant);
    end
    cons_sub     = 4'b0001;
    cons_ready   = 4'b1111;
    buffer_ready = 1'b1;
    run_frame(20, 1'b0);
    buffer_ready = 1'b0;
    vectors++;
    if (pop_k !== 2 || pops_n !== 1 || gq.size() !== 1) begin
      miscompares++;
      $display("FAIL rst_next_frame: pop k=%0d count=%0d grants=%0d, want 2/1/1", pop_k, pops_n, gq.size());
    end
  endtask

`ifdef BUF_AUDIO_RD_SCHED_STATS_EN
  task automatic test_stats();
    int n;
    do_reset();
    cons_sub      = 4'b0001;
    cons_pair_sel = 4'b0000;
    cons_ready    = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      buffer_ready = 1'b1;
      n = 0;
      while (cons_grant == 0 && n < 20) begin
        @(negedge sys_clk);
        n++;
      end
      buffer_ready = 1'b0;
      if (f == 1 || f == 3) begin
        buffer_full = 1'b1;
        @(negedge sys_clk);
        buffer_full = 1'b0;
      end
      n = 0;
      while (!frame_done && n < 20) begin
        @(negedge sys_clk);
        n++;
      end
    end
    repeat (3) @(negedge sys_clk);
    buffer_full = 1'b1;
    @(negedge sys_clk);
    buffer_full = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if (stat_frames !== 32'd5) begin
      miscompares++;
      $display("FAIL stat_frames: got %0d, want 5", stat_frames);
    end
    vectors++;
    if (stat_overruns !== 16'd2) begin
      miscompares++;
      $display("FAIL stat_overruns: got %0d, want 2", stat_overruns);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_serve();
    test_round_robin();
    test_timeout();
    test_mid_frame_reset();
    test_no_subscribers();
`ifdef BUF_AUDIO_RD_SCHED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/buf_audio_rd_sched.md
Name: buf_audio_rd_sched

Overview:
- Read-side scheduler for the I2S input buffer.
- Pops one frame (all stereo pairs) from the buffer when one is available and latches it into a frame register.
- Serves the latched frame to up to NUM_CONSUMERS DSP consumers over one shared stereo output bus, using round-robin arbitration and a valid/ready handshake.
- Sits between buf_audio_in and the DSP core array; it is the only block that drives the buffer's read controls.

Parameters:
- NUM_AUDIO_CHANNELS, 2, number of stereo pairs in buf_audio_in.
- AUDIO_WIDTH, 24, bits per mono sample.
- NUM_CONSUMERS, 4, number of requesting DSP consumers.
- TIMEOUT_CYCLES, 1024, maximum number of cycles a grant is held without cons_ready.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- buffer_ready  in  1  buf_audio_in holds at least one frame.
- buffer_full  in  1  buf_audio_in is full; the producer will drop the oldest frame.
- audio_channel_in  in  AUDIO_WIDTH x (2*NUM_AUDIO_CHANNELS)  head-of-FIFO samples; index 2p is L, 2p+1 is R.
- adv_read_req  out  1  read-port ownership request to buf_audio_in.
- adv_read_enable  out  1  single-cycle pop strobe.
- cons_sub  in  NUM_CONSUMERS  subscription mask; a set bit means the consumer receives every frame.
- cons_pair_sel  in  NUM_CONSUMERS x clog2(NUM_AUDIO_CHANNELS)  stereo pair wanted by each consumer.
- cons_ready  in  NUM_CONSUMERS  consumer accepts the output bus this cycle.
- cons_grant  out  NUM_CONSUMERS  one-hot grant; acts as the per-consumer valid.
- out_left  out  AUDIO_WIDTH  L sample of the granted consumer's pair.
- out_right  out  AUDIO_WIDTH  R sample of the granted consumer's pair.
- frame_done  out  1  one-cycle pulse when every pending consumer has been served or dropped.
- timeout_err  out  NUM_CONSUMERS  sticky per-consumer timeout flag; cleared only by reset.

Behaviour:
- Reset (sys_rst=0, asynchronous):
  - State is IDLE; all outputs are 0; frame register, pending mask, round-robin pointer and timeout counter are all 0.
  - Reset asserted mid-frame abandons the frame. The popped data is lost; no re-pop occurs.
- IDLE:
  - adv_read_req=0.
  - Go to LATCH when buffer_ready=1 and cons_sub!=0.
  - With cons_sub==0 the block never pops; the buffer fills and overwrites, which is intended.
- LATCH (1 cycle):
  - adv_read_req=1.
  - audio_channel_in is registered into the frame register.
  - cons_sub is snapshotted into the pending mask.
  - cons_pair_sel is snapshotted per consumer.
  - Go to POP.
- POP (1 cycle):
  - adv_read_req=1 and adv_read_enable=1, exactly one pulse per frame.
  - Go to SERVE.
- SERVE:
  - adv_read_req=0.
  - The rr_arbiter grants the lowest pending index at or after the round-robin pointer.
  - The grant is registered and held stable until one of these events:
    - cons_ready of the granted consumer = 1: transfer; clear its pending bit.
    - The timeout counter reaches TIMEOUT_CYCLES-1: set timeout_err[i]; clear its pending bit.
  - After either event:
    - The round-robin pointer moves to granted index+1 (mod NUM_CONSUMERS).
    - The timeout counter resets.
    - One idle cycle follows with cons_grant=0.
    - The next grant is issued on the cycle after that.
  - out_left/out_right equal the frame register entries for the granted consumer's snapshotted pair. They are don't-care while no grant is active but are driven as 0.
  - When the pending mask becomes 0: frame_done=1 for one cycle; go to IDLE.
- Latency:
  - buffer_ready high in IDLE gives adv_read_enable two cycles later.
  - The first cons_grant follows one cycle after that (3 cycles total).
  - Minimum consumer-to-consumer spacing is 2 cycles.
- Boundary conditions:
  - cons_sub and cons_pair_sel changes during SERVE do not affect the current frame.
  - buffer_ready dropping after LATCH is ignored; the pop still occurs.
  - buffer_full during SERVE takes no action in base build.
  - A ready/timeout tie in the same cycle counts as a transfer; no error is flagged.
  - A cons_pair_sel value ≥ NUM_AUDIO_CHANNELS is clamped to pair 0.

Optional Feature:
- Macro: BUF_AUDIO_RD_SCHED_STATS_EN.
- Defined:
  - Adds output stat_frames [31:0]: frames popped, wrapping.
  - Adds output stat_overruns [15:0]: rising edges of buffer_full seen while not IDLE, saturating at 16'hFFFF.
  - Both counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package buf_audio_rd_pkg:
  - sched_state_t enum (IDLE, LATCH, POP, SERVE).
  - STEREO_MULTIPLIER=2.
  - pair_idx_t and cons_idx_t typedef widths.
  - Timeout counter width derived from TIMEOUT_CYCLES.
- Sub-module rr_arbiter: parameterised width; inputs are the request mask and pointer; output is a one-hot grant. Purely combinational; registered by the parent.

Test Plan:
- Frame serve: cons_sub=4'b0011, pair_sel={0,1}, frame L0=0x123456 R0=0xABCDEF L1=0x111111 R1=0x222222, cons_ready tied 1. Expect:
  - adv_read_enable pulses once.
  - Consumer 0 gets 0x123456/0xABCDEF, then consumer 1 gets 0x111111/0x222222.
  - frame_done pulses; state returns to IDLE.
- Round-robin fairness: all 4 subscribed, 3 consecutive frames. Grant order per frame is 0,1,2,3 and each consumer is served once per frame. Exactly 3 pops occur.
- Backpressure and timeout: TIMEOUT_CYCLES=8, consumer 1 holds cons_ready=0. Expect:
  - The grant holds for 8 cycles.
  - timeout_err=4'b0010, sticky.
  - Consumer 2 is served next; frame_done still pulses.
- No subscribers: cons_sub=0 with buffer_ready=1 for 100 cycles gives adv_read_enable=0 throughout. Setting cons_sub=1 gives a pop 2 cycles later.
- Mid-frame reset: assert sys_rst=0 during SERVE. Expect:
  - All outputs are 0 asynchronously.
  - timeout_err is cleared.
  - After release, the next frame is served from IDLE with no extra pop.
- Stats (macro defined): 5 frames served and buffer_full pulsed twice while in SERVE give stat_frames=5 and stat_overruns=2.
